// File: rtl/ex_operand_muldiv.sv
// Execute-stage operand muxes plus an iterative signed/unsigned multiply/divide
// unit owning the HI/LO registers; busy stalls the pipeline while it runs.
module ex_operand_muldiv #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned ITER  = 32
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic [WIDTH-1:0] bus_a,
  input  logic [WIDTH-1:0] bus_b,
  input  logic [WIDTH-1:0] imm_32,
  input  logic [WIDTH-1:0] mem_alu_out,
  input  logic [WIDTH-1:0] wb_bus_w,
  input  logic [1:0]       a_sel,
  input  logic [1:0]       b_sel,
  input  logic [2:0]       op,
  input  logic             start,
  input  logic             flush,
  output logic [WIDTH-1:0] op_a,
  output logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int unsigned AW = 2 * WIDTH;
  localparam int unsigned CW = (ITER > 1) ? $clog2(ITER) : 1;

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  state_t           state;
  logic [CW-1:0]    count;
  logic [AW-1:0]    acc;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] dividend_q;
  logic             is_div_q;
  logic             neg_res_q;
  logic             neg_rem_q;
  logic             div_zero_q;

  // Forwarding muxes: always live, independent of the FSM
  always_comb begin
    op_a = bus_a;
    case (a_sel)
      2'b10:   op_a = mem_alu_out;
      2'b11:   op_a = wb_bus_w;
      default: op_a = bus_a;
    endcase
    op_b = bus_b;
    case (b_sel)
      2'b01:   op_b = imm_32;
      2'b10:   op_b = mem_alu_out;
      2'b11:   op_b = wb_bus_w;
      default: op_b = bus_b;
    endcase
  end

  logic             op_is_muldiv;
  logic             op_signed;
  logic             op_is_div;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Operand capture: signed ops work on magnitudes, signs fixed up in FIN
  always_comb begin
    op_is_muldiv = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    op_signed    = (op == OP_MULT) || (op == OP_DIV);
    op_is_div    = (op == OP_DIV) || (op == OP_DIVU);
    a_mag        = (op_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    b_mag        = (op_signed && op_b[WIDTH-1]) ? -op_b : op_b;
  end

  logic [WIDTH:0]  mul_sum;
  logic [WIDTH:0]  div_top;
  logic [WIDTH:0]  div_diff;
  logic [AW-1:0]   acc_step;

  // One shift-add (mul) or restoring-subtract (div) step per cycle
  always_comb begin
    mul_sum  = {1'b0, acc[AW-1:WIDTH]} + {1'b0, b_q};
    div_top  = acc[AW-1:WIDTH-1];
    div_diff = div_top - {1'b0, b_q};
    acc_step = acc;
    if (is_div_q) begin
      if (!div_diff[WIDTH])
        acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else
        acc_step = {acc[AW-2:0], 1'b0};
    end else begin
      if (acc[0])
        acc_step = {mul_sum, acc[WIDTH-1:1]};
      else
        acc_step = {1'b0, acc[AW-1:1]};
    end
  end

  logic [AW-1:0]    prod;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  always_comb begin
    prod = neg_res_q ? -acc : acc;
    quo  = neg_res_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem  = neg_rem_q ? -acc[AW-1:WIDTH] : acc[AW-1:WIDTH];
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state      <= ST_IDLE;
      count      <= '0;
      acc        <= '0;
      b_q        <= '0;
      dividend_q <= '0;
      is_div_q   <= 1'b0;
      neg_res_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      div_zero_q <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !flush) begin
            if (op_is_muldiv) begin
              state      <= ST_RUN;
              count      <= '0;
              busy       <= 1'b1;
              acc        <= {{WIDTH{1'b0}}, a_mag};
              b_q        <= b_mag;
              dividend_q <= op_a;
              is_div_q   <= op_is_div;
              neg_res_q  <= op_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
              neg_rem_q  <= op_signed && op_a[WIDTH-1];
              div_zero_q <= op_is_div && (op_b == '0);
            end else if (op == OP_MTHI) begin
              hi <= op_a;
            end else if (op == OP_MTLO) begin
              lo <= op_a;
            end
          end
        end
        ST_RUN: begin
          if (flush) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else begin
            acc   <= acc_step;
            count <= count + CW'(1);
            if (count == CW'(ITER - 1))
              state <= ST_FIN;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          if (!flush) begin
            done <= 1'b1;
            if (!is_div_q) begin
              hi <= prod[AW-1:WIDTH];
              lo <= prod[WIDTH-1:0];
            end else if (div_zero_q) begin
              hi <= dividend_q;
              lo <= '1;
            end else begin
              hi <= rem;
              lo <= quo;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_operand_muldiv.sv
// Directed self-checking bench for ex_operand_muldiv.
module tb_ex_operand_muldiv;

  logic        CLK;
  logic        nRST;
  logic [31:0] bus_a, bus_b, imm_32, mem_alu_out, wb_bus_w;
  logic [1:0]  a_sel, b_sel;
  logic [2:0]  op;
  logic        start, flush;
  logic [31:0] op_a, op_b, hi, lo;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  ex_operand_muldiv #(.WIDTH(32), .ITER(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .bus_a(bus_a), .bus_b(bus_b), .imm_32(imm_32),
    .mem_alu_out(mem_alu_out), .wb_bus_w(wb_bus_w),
    .a_sel(a_sel), .b_sel(b_sel), .op(op),
    .start(start), .flush(flush),
    .op_a(op_a), .op_b(op_b), .hi(hi), .lo(lo),
    .busy(busy), .done(done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge of the done cycle (k+34).
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo);
    int bcnt;
    int dcnt;
    bcnt = 0;
    dcnt = 0;
    a_sel = 2'b00; b_sel = 2'b00;
    bus_a = a; bus_b = b; op = o; start = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0; op = 3'b000;
    for (int i = 0; i < 33; i++) begin
      if (busy === 1'b1) bcnt++;
      if (done === 1'b1) dcnt++;
      @(negedge CLK);
    end
    chk({tag, "_busy_cycles"}, 64'(bcnt), 64'd33);
    chk({tag, "_early_done"}, 64'(dcnt), 64'd0);
    chk({tag, "_busy_end"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    int dcnt;
    nRST = 1'b0; start = 1'b0; flush = 1'b0; op = 3'b000;
    a_sel = 2'b00; b_sel = 2'b00;
    bus_a = 32'd1; bus_b = 32'd2; imm_32 = 32'd3; mem_alu_out = 32'd4; wb_bus_w = 32'd5;
    repeat (3) @(negedge CLK);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    nRST = 1'b1;
    @(negedge CLK);

    // Operand mux sweep
    a_sel = 2'b00; #1 chk("mux_a00", 64'(op_a), 64'd1);
    a_sel = 2'b01; #1 chk("mux_a01", 64'(op_a), 64'd1);
    a_sel = 2'b10; #1 chk("mux_a10", 64'(op_a), 64'd4);
    a_sel = 2'b11; #1 chk("mux_a11", 64'(op_a), 64'd5);
    b_sel = 2'b00; #1 chk("mux_b00", 64'(op_b), 64'd2);
    b_sel = 2'b01; #1 chk("mux_b01", 64'(op_b), 64'd3);
    b_sel = 2'b10; #1 chk("mux_b10", 64'(op_b), 64'd4);
    b_sel = 2'b11; #1 chk("mux_b11", 64'(op_b), 64'd5);
    a_sel = 2'b00; b_sel = 2'b00;
    @(negedge CLK);

    // Arithmetic, MULTU/DIVU issued back-to-back in the done cycle
    run_op("mult", 3'b001, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    @(negedge CLK);
    chk("mult_done_pulse", 64'(done), 64'd0);
    run_op("multu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("divu", 3'b100, 32'd100, 32'd7, 32'd2, 32'd14);
    @(negedge CLK);
    chk("divu_done_pulse", 64'(done), 64'd0);
    run_op("div_neg", 3'b011, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    @(negedge CLK);
    run_op("div_zero", 3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    @(negedge CLK);
    run_op("div_ovf", 3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
    @(negedge CLK);

    // MTHI then MTLO on consecutive cycles
    bus_a = 32'h0000_ABCD; op = 3'b101; start = 1'b1;
    @(negedge CLK);
    chk("mthi_hi", 64'(hi), 64'h0000_ABCD);
    chk("mthi_busy", 64'(busy), 64'd0);
    bus_a = 32'h0000_1234; op = 3'b110;
    @(negedge CLK);
    start = 1'b0; op = 3'b000;
    chk("mtlo_lo", 64'(lo), 64'h0000_1234);
    chk("mtlo_hi", 64'(hi), 64'h0000_ABCD);
    chk("mtlo_busy", 64'(busy), 64'd0);
    chk("mtlo_done", 64'(done), 64'd0);

    // Flush wins over start in IDLE
    bus_a = 32'h0000_7777; op = 3'b101; start = 1'b1; flush = 1'b1;
    @(negedge CLK);
    start = 1'b0; flush = 1'b0; op = 3'b000;
    chk("idle_flush_hi", 64'(hi), 64'h0000_ABCD);

    // Abort: preload HI/LO, start MULT, ignored start mid-run, flush at count 10
    bus_a = 32'h11; op = 3'b101; start = 1'b1;
    @(negedge CLK);
    bus_a = 32'h22; op = 3'b110;
    @(negedge CLK);
    bus_a = 32'd6; bus_b = 32'd7; op = 3'b001;
    @(posedge CLK);
    @(negedge CLK);
    start = 1'b0; op = 3'b000;
    for (int i = 1; i <= 10; i++) begin
      if (i == 4) begin bus_a = 32'h99; op = 3'b101; start = 1'b1; end
      if (i == 5) begin start = 1'b0; op = 3'b000; end
      @(negedge CLK);
    end
    chk("abort_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("abort_busy_after", 64'(busy), 64'd0);
    dcnt = 0;
    for (int i = 0; i < 30; i++) begin
      if (done === 1'b1) dcnt++;
      @(negedge CLK);
    end
    chk("abort_no_done", 64'(dcnt), 64'd0);
    chk("abort_hi", 64'(hi), 64'h11);
    chk("abort_lo", 64'(lo), 64'h22);
    chk("abort_idle_busy", 64'(busy), 64'd0);

    // Reset in the middle of a DIVU
    bus_a = 32'd1000; bus_b = 32'd3; op = 3'b100; start = 1'b1;
    @(negedge CLK);
    start = 1'b0; op = 3'b000;
    repeat (5) @(negedge CLK);
    chk("mid_busy", 64'(busy), 64'd1);
    nRST = 1'b0;
    #1;
    chk("mid_rst_hi", 64'(hi), 64'd0);
    chk("mid_rst_lo", 64'(lo), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    @(negedge CLK);
    nRST = 1'b1;
    repeat (40) @(negedge CLK);
    chk("post_rst_done", 64'(done), 64'd0);
    chk("post_rst_lo", 64'(lo), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
